control_cmd_fillrect_clip: RTL and testbench

Parametrised successor to the fillrect command engine. Consumes a byte-serial command (mode, x, y, width, height, colour) from the command decoder and issues one framebuffer byte write per cycle. Adds panel-edge clipping, a generic bytes-per-pixel width and an optional outline mode. Sits between the command dispatcher and the framebuffer write port on a single clock.

---
 rtl/control_cmd_fillrect_clip.sv | 210 +++++++++++++++++++++
 tb/tb_control_cmd_fillrect_clip.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_cmd_fillrect_clip.sv
// control_cmd_fillrect_clip
//
// Captures a byte-serial rectangle command (MODE, X, Y, W, H, colour bytes MSB first).
// It then issues one framebuffer byte write per enabled cycle. The rectangle is traversed
// row-major and clipped against the panel edges.
//
// Optional outline mode is built only when CONTROL_CMD_FILLRECT_OUTLINE_EN is defined.
// When it is undefined, MODE is consumed and ignored, and every command is a fill.
//
// Ports:
//   clk              single clock
//   reset            asynchronous, active-high reset
//   enable           byte valid while capturing; run/pause while writing
//   data_in          command byte stream
//   row, column      write address
//   pixel            byte lane within the pixel (lane 0 carries the colour MSB)
//   data_out         colour byte for the current lane; holds while no write
//   ram_write_enable write strobe
//   ram_access_start pulse alongside the first write of a command
//   ready_for_data   high while capturing command bytes
//   done             one-cycle pulse when a command completes
module control_cmd_fillrect_clip #(
    parameter int BYTES_PER_PIXEL = 2,
    parameter int NUM_ROWS        = 32,
    parameter int NUM_COLS        = 64,
    parameter int ROW_BITS        = $clog2(NUM_ROWS),
    parameter int COL_BITS        = $clog2(NUM_COLS),
    parameter int PIXEL_BITS      = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [7:0]            data_in,
    output logic [ROW_BITS-1:0]   row,
    output logic [COL_BITS-1:0]   column,
    output logic [PIXEL_BITS-1:0] pixel,
    output logic [7:0]            data_out,
    output logic                  ram_write_enable,
    output logic                  ram_access_start,
    output logic                  ready_for_data,
    output logic                  done
);

    localparam logic [1:0] ST_CAPTURE = 2'd0;
    localparam logic [1:0] ST_WRITE   = 2'd1;
    localparam logic [1:0] ST_FINISH  = 2'd2;

    localparam logic [3:0]            LAST_BYTE_CNT = 4'(4 + BYTES_PER_PIXEL);
    localparam logic [PIXEL_BITS-1:0] LAST_LANE     = PIXEL_BITS'(BYTES_PER_PIXEL - 1);

    logic [1:0]            r_state;
    logic                  r_alive;      // keeps ready_for_data low until the first edge out of reset
    logic [3:0]            r_byte_cnt;
    logic [7:0]            r_x;
    logic [7:0]            r_y;
    logic [7:0]            r_w;
    logic [7:0]            r_h;
    logic [7:0]            r_colour [0:BYTES_PER_PIXEL-1];  // index 0 = first streamed byte (MSB)
    logic [ROW_BITS-1:0]   r_row;
    logic [COL_BITS-1:0]   r_col;
    logic [PIXEL_BITS-1:0] r_pix;
    logic                  r_first;
    logic [7:0]            r_last_data;

    logic                  w_accept;
    logic                  w_we;
    logic [8:0]            w_x_sum;
    logic [8:0]            w_y_sum;
    logic [8:0]            w_x_end;
    logic [8:0]            w_y_end;
    logic                  w_empty;
    logic [8:0]            w_col9;
    logic [8:0]            w_row9;
    logic                  w_col_last;
    logic                  w_row_last;
    logic                  w_jump;        // interior outline row: skip from X to X+W-1
    logic                  w_wrap_early;  // interior outline row whose right edge is absent
    logic [COL_BITS-1:0]   w_right_col;
    logic [7:0]            w_lane_data;

    assign w_accept    = ready_for_data && enable;
    assign w_we        = (r_state == ST_WRITE) && enable;

    // Extents in 9 bits so X+W and Y+H never wrap.
    assign w_x_sum     = {1'b0, r_x} + {1'b0, r_w};
    assign w_y_sum     = {1'b0, r_y} + {1'b0, r_h};
    assign w_x_end     = (w_x_sum > 9'(NUM_COLS)) ? 9'(NUM_COLS) : w_x_sum;
    assign w_y_end     = (w_y_sum > 9'(NUM_ROWS)) ? 9'(NUM_ROWS) : w_y_sum;
    assign w_empty     = (r_w == 8'd0) || (r_h == 8'd0) ||
                         ({1'b0, r_x} >= 9'(NUM_COLS)) || ({1'b0, r_y} >= 9'(NUM_ROWS));

    assign w_col9      = 9'(r_col);
    assign w_row9      = 9'(r_row);
    assign w_col_last  = (w_col9 + 9'd1) == w_x_end;
    assign w_row_last  = (w_row9 + 9'd1) == w_y_end;
    assign w_lane_data = r_colour[r_pix];

`ifdef CONTROL_CMD_FILLRECT_OUTLINE_EN
    logic       r_outline;
    logic [8:0] w_x_right;
    logic       w_interior;
    logic       w_skip;
    logic       w_right_in;

    assign w_x_right    = w_x_sum - 9'd1;
    assign w_interior   = (w_row9 != {1'b0, r_y}) && (w_row9 != (w_y_sum - 9'd1));
    // Interior rows only ever visit the left edge X and, if present, the right edge.
    assign w_skip       = r_outline && w_interior && (w_col9 == {1'b0, r_x});
    assign w_right_in   = (w_x_right < 9'(NUM_COLS)) && (r_w > 8'd1);
    assign w_jump       = w_skip && w_right_in;
    assign w_wrap_early = w_skip && !w_right_in;
    assign w_right_col  = w_x_right[COL_BITS-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outline <= 1'b0;
        end else if (w_accept && (r_byte_cnt == 4'd0)) begin
            r_outline <= data_in[0];
        end
    end
`else
    assign w_jump       = 1'b0;
    assign w_wrap_early = 1'b0;
    assign w_right_col  = r_col;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_CAPTURE;
            r_alive     <= 1'b0;
            r_byte_cnt  <= 4'd0;
            r_x         <= 8'd0;
            r_y         <= 8'd0;
            r_w         <= 8'd0;
            r_h         <= 8'd0;
            for (int i = 0; i < BYTES_PER_PIXEL; i++) begin
                r_colour[i] <= 8'd0;
            end
            r_row       <= '0;
            r_col       <= '0;
            r_pix       <= '0;
            r_first     <= 1'b0;
            r_last_data <= 8'd0;
        end else begin
            r_alive <= 1'b1;
            case (r_state)
                ST_CAPTURE: begin
                    if (w_accept) begin
                        r_byte_cnt <= r_byte_cnt + 4'd1;
                        case (r_byte_cnt)
                            4'd1:    r_x <= data_in;
                            4'd2:    r_y <= data_in;
                            4'd3:    r_w <= data_in;
                            4'd4:    r_h <= data_in;
                            default: ;
                        endcase
                        for (int i = 0; i < BYTES_PER_PIXEL; i++) begin
                            if (r_byte_cnt == 4'(5 + i)) begin
                                r_colour[i] <= data_in;
                            end
                        end
                        if (r_byte_cnt == LAST_BYTE_CNT) begin
                            r_byte_cnt <= 4'd0;
                            r_row      <= r_y[ROW_BITS-1:0];
                            r_col      <= r_x[COL_BITS-1:0];
                            r_pix      <= '0;
                            r_first    <= 1'b1;
                            r_state    <= w_empty ? ST_FINISH : ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (enable) begin
                        r_first     <= 1'b0;
                        r_last_data <= w_lane_data;
                        if (r_pix != LAST_LANE) begin
                            r_pix <= r_pix + PIXEL_BITS'(1);
                        end else begin
                            r_pix <= '0;
                            if (w_jump) begin
                                r_col <= w_right_col;
                            end else if (w_col_last || w_wrap_early) begin
                                r_col <= r_x[COL_BITS-1:0];
                                if (w_row_last) begin
                                    r_state <= ST_FINISH;
                                end else begin
                                    r_row <= r_row + ROW_BITS'(1);
                                end
                            end else begin
                                r_col <= r_col + COL_BITS'(1);
                            end
                        end
                    end
                end
                ST_FINISH: r_state <= ST_CAPTURE;
                default:   r_state <= ST_CAPTURE;
            endcase
        end
    end

    assign row              = r_row;
    assign column           = r_col;
    assign pixel            = r_pix;
    assign ram_write_enable = w_we;
    assign ram_access_start = w_we && r_first;
    assign data_out         = w_we ? w_lane_data : r_last_data;
    assign ready_for_data   = (r_state == ST_CAPTURE) && r_alive;
    assign done             = (r_state == ST_FINISH);

endmodule

// File: tb/tb_control_cmd_fillrect_clip.sv
module tb_control_cmd_fillrect_clip;

    localparam int BPP = 2;
    localparam int NR  = 32;
    localparam int NC  = 64;
`ifdef CONTROL_CMD_FILLRECT_OUTLINE_EN
    localparam bit OL = 1'b1;
`else
    localparam bit OL = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       enable;
    logic [7:0] data_in;
    logic [4:0] row;
    logic [5:0] column;
    logic [0:0] pixel;
    logic [7:0] data_out;
    logic       ram_write_enable;
    logic       ram_access_start;
    logic       ready_for_data;
    logic       done;

    control_cmd_fillrect_clip dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .data_in          (data_in),
        .row              (row),
        .column           (column),
        .pixel            (pixel),
        .data_out         (data_out),
        .ram_write_enable (ram_write_enable),
        .ram_access_start (ram_access_start),
        .ready_for_data   (ready_for_data),
        .done             (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int r;
        int c;
        int p;
        int d;
        bit first;
    } wr_t;

    wr_t exp_q[$];
    bit  wmap [0:NR-1][0:NC-1][0:BPP-1];
    int  n_cmp    = 0;
    int  n_bad    = 0;
    int  wr_cnt   = 0;
    int  done_cnt = 0;
    int  exp_done = 0;
    logic [7:0] last_d = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: enumerate the clipped rectangle directly from the command rules.
    function automatic int build(input int mode, input int x, input int y, input int w,
                                 input int h, input int colour);
        int xe;
        int ye;
        int n;
        bit ol;
        bit border;
        wr_t e;
        n  = 0;
        ol = OL && mode[0];
        if (w == 0 || h == 0 || x >= NC || y >= NR) return 0;
        xe = (x + w > NC) ? NC : x + w;
        ye = (y + h > NR) ? NR : y + h;
        for (int r = y; r < ye; r++) begin
            for (int c = x; c < xe; c++) begin
                border = (r == y) || (r == y + h - 1) || (c == x) || (c == x + w - 1);
                if (!ol || border) begin
                    for (int p = 0; p < BPP; p++) begin
                        e.r     = r;
                        e.c     = c;
                        e.p     = p;
                        e.d     = (colour >> (8 * (BPP - 1 - p))) & 8'hFF;
                        e.first = (n == 0);
                        exp_q.push_back(e);
                        n++;
                    end
                end
            end
        end
        return n;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            last_d = 8'd0;
        end else begin
            if (ram_write_enable) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_row", 32'(row), 32'(e.r));
                    check("wr_col", 32'(column), 32'(e.c));
                    check("wr_pixel", 32'(pixel), 32'(e.p));
                    check("wr_data", 32'(data_out), 32'(e.d));
                    check("wr_start", 32'(ram_access_start), 32'(e.first));
                end
                if (wmap[row][column][pixel]) check("dup_write", 32'd1, 32'd0);
                wmap[row][column][pixel] = 1'b1;
                wr_cnt++;
                last_d = data_out;
            end else begin
                check("data_hold", 32'(data_out), 32'(last_d));
                if (ram_access_start) check("start_without_we", 32'd1, 32'd0);
            end
            if (done) done_cnt++;
        end
    end

    task automatic clear_map();
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                for (int p = 0; p < BPP; p++)
                    wmap[r][c][p] = 1'b0;
        wr_cnt = 0;
    endtask

    // Returns 1ns after the edge that accepted the last colour byte; enable left high.
    task automatic send_cmd(input int mode, input int x, input int y, input int w, input int h,
                            input int colour);
        logic [7:0] b [0:4+BPP];
        int t;
        b[0] = 8'(mode);
        b[1] = 8'(x);
        b[2] = 8'(y);
        b[3] = 8'(w);
        b[4] = 8'(h);
        for (int i = 0; i < BPP; i++) b[5+i] = 8'((colour >> (8 * (BPP - 1 - i))) & 8'hFF);
        t = 0;
        while (!ready_for_data && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!ready_for_data) check("ready_timeout", 32'd0, 32'd1);
        for (int i = 0; i < 5 + BPP; i++) begin
            enable  = 1'b1;
            data_in = b[i];
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        enable = 1'b0;
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        check({name, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
        exp_done++;
        @(negedge clk);
        check({name, "_done_one_cycle"}, 32'(done), 32'd0);
        check({name, "_ready_after"}, 32'(ready_for_data), 32'd1);
        check({name, "_done_count"}, 32'(done_cnt), 32'(exp_done));
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input string name, input int mode, input int x, input int y,
                           input int w, input int h, input int colour, input int exp_writes,
                           input int budget);
        int n;
        clear_map();
        n = build(mode, x, y, w, h, colour);
        check({name, "_model_count"}, 32'(n), 32'(exp_writes));
        send_cmd(mode, x, y, w, h, colour);
        if (exp_writes == 0) enable = 1'b0;
        wait_done(name, budget);
        check({name, "_write_count"}, 32'(wr_cnt), 32'(exp_writes));
    endtask

    initial begin
        int n;
        logic [4:0] fr;
        logic [5:0] fc;
        logic [0:0] fp;

        reset   = 1'b1;
        enable  = 1'b0;
        data_in = 8'd0;
        #3;
        check("reset_outputs", {row, column, pixel, data_out, ram_write_enable,
                                ram_access_start, ready_for_data, done}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("ready_low_before_edge", 32'(ready_for_data), 32'd0);
        @(posedge clk);
        #1;
        check("ready_after_reset", 32'(ready_for_data), 32'd1);

        // 2x2 fill, model pinned to hand values.
        clear_map();
        n = build(0, 1, 1, 2, 2, 'hBEEF);
        check("t1_model_count", 32'(n), 32'd8);
        check("t1_model_lane0", 32'(exp_q[0].d), 32'hBE);
        check("t1_model_lane1", 32'(exp_q[1].d), 32'hEF);
        check("t1_model_last_row", 32'(exp_q[7].r), 32'd2);
        send_cmd(0, 1, 1, 2, 2, 'hBEEF);
        wait_done("t1", 100);
        check("t1_write_count", 32'(wr_cnt), 32'd8);
        check("t1_written_2_2", 32'(wmap[2][2][1]), 32'd1);

        run_cmd("t2_clip_corner", 0, 62, 30, 4, 4, 'h5AC3, 8, 100);
        run_cmd("t3_w0", 0, 10, 10, 0, 4, 'h1111, 0, 2);
        run_cmd("t3_x70", 0, 70, 3, 4, 4, 'h2222, 0, 2);
        run_cmd("t3_h0_y40", 0, 3, 40, 4, 4, 'h3333, 0, 2);

        run_cmd("t4_outline", 1, 0, 0, 4, 3, 'h1234, OL ? 20 : 24, 100);
        check("t4_interior_1_1", 32'(wmap[1][1][0]), OL ? 32'd0 : 32'd1);
        check("t4_interior_1_2", 32'(wmap[1][2][1]), OL ? 32'd0 : 32'd1);
        check("t4_edge_1_3", 32'(wmap[1][3][0]), 32'd1);
        run_cmd("t4_outline_clip", 1, 62, 30, 4, 4, 'hABCD, OL ? 6 : 8, 100);
        run_cmd("t4_outline_line", 1, 5, 5, 1, 3, 'h0102, 6, 100);
        run_cmd("t4_fill_mode_bits", 8'hFE, 7, 7, 3, 3, 'h7788, 18, 100);

        // Pause mid-write.
        clear_map();
        n = build(0, 3, 4, 2, 2, 'hA55A);
        check("t5_model_count", 32'(n), 32'd8);
        send_cmd(0, 3, 4, 2, 2, 'hA55A);
        repeat (3) @(posedge clk);
        #1;
        enable = 1'b0;
        @(negedge clk);
        check("t5_writes_before_gap", 32'(wr_cnt), 32'd3);
        fr = row;
        fc = column;
        fp = pixel;
        check("t5_gap_we", 32'(ram_write_enable), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t5_gap_we", 32'(ram_write_enable), 32'd0);
            check("t5_gap_addr", {row, column, pixel}, {fr, fc, fp});
        end
        @(posedge clk);
        #1;
        enable = 1'b1;
        wait_done("t5", 100);
        check("t5_write_count", 32'(wr_cnt), 32'd8);

        // Reset mid-command.
        clear_map();
        n = build(0, 0, 0, 2, 2, 'h0F0F);
        check("t6_model_count", 32'(n), 32'd8);
        send_cmd(0, 0, 0, 2, 2, 'h0F0F);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("t6_reset_outputs", {row, column, pixel, data_out, ram_write_enable,
                                   ram_access_start, ready_for_data, done}, 32'd0);
        check("t6_writes_before_reset", 32'(wr_cnt), 32'd3);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        enable = 1'b0;
        #1;
        check("t6_ready_low_before_edge", 32'(ready_for_data), 32'd0);
        @(posedge clk);
        #1;
        check("t6_ready_after_reset", 32'(ready_for_data), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("t6_no_writes_after_reset", 32'(wr_cnt), 32'd3);
        run_cmd("t6_new_cmd", 0, 0, 0, 2, 2, 'hC0DE, 8, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

endmodule
